jtframe_bank_arbiter: RTL and testbench

//  Round-robin arbiter sharing one SDRAM bank read port (ba_rd/ba_addr/ba_ack/ba_rdy)

---
 rtl/jtframe_bank_arbiter.sv | 156 +++++++++++++++
 tb/tb_jtframe_bank_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_bank_arbiter.sv
// jtframe_bank_arbiter
// Round-robin arbiter that shares one SDRAM bank read port between SLOTS ROM
// requesters. A grant latches the winner's address and raises ba_rd until the
// controller acks. The read data is captured on ba_rdy and returned with a
// one-cycle slot_ok pulse. New grants are held off while a ROM download runs.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   downloading   ROM download active: blocks new grants only
//   slot_req      per-slot level request, held until slot_ok
//   slot_addr     per-slot address, slot i = [i*AW +: AW]
//   slot_ok       one-hot (or zero) data-valid pulse for the granted slot
//   slot_dout     captured read data, held until the next capture
//   ba_rd         bank read request, held until ba_ack
//   ba_addr       bank address latched at grant
//   ba_ack        controller accepted the request
//   ba_rdy        read data valid on sdram_dout
//   sdram_dout    SDRAM read data
//   busy          arbiter is not idle
module jtframe_bank_arbiter #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22,
    parameter int unsigned DW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [DW-1:0]       slot_dout,
    output logic                ba_rd,
    output logic [AW-1:0]       ba_addr,
    input  logic                ba_ack,
    input  logic                ba_rdy,
    input  logic [DW-1:0]       sdram_dout,
    output logic                busy
);

    localparam int unsigned GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, grant_nxt;
    logic [GW-1:0]   rr, rr_nxt;
    logic [GW-1:0]   win;
    logic            win_vld;
    logic [GW-1:0]   grant_inc;
    logic            done;
    logic            ba_rd_nxt;
    logic [AW-1:0]   ba_addr_nxt;
    logic [SLOTS-1:0] slot_ok_nxt;
    logic [DW-1:0]   slot_dout_nxt;
    logic            busy_nxt;
    logic [AW-1:0]   addr_arr [SLOTS];

    // Slot k positions after base, wrapping modulo SLOTS
    function automatic logic [GW-1:0] rr_slot(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % int'(SLOTS);
        return GW'(s);
    endfunction

    // Unpack the flat address bus
    for (genvar i = 0; i < int'(SLOTS); i++) begin : g_addr
        assign addr_arr[i] = slot_addr[i*AW +: AW];
    end

    // Rotating priority: scan from the far end so the nearest requester wins last
    always_comb begin
        win     = rr;
        win_vld = 1'b0;
        for (int k = int'(SLOTS) - 1; k >= 0; k--) begin
            if (slot_req[rr_slot(rr, k)]) begin
                win     = rr_slot(rr, k);
                win_vld = 1'b1;
            end
        end
    end

    assign grant_inc = (grant == GW'(SLOTS - 1)) ? '0 : grant + GW'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_nxt        = rr;
        ba_rd_nxt     = ba_rd;
        ba_addr_nxt   = ba_addr;
        slot_ok_nxt   = '0;
        slot_dout_nxt = slot_dout;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && win_vld) begin
                    state_nxt   = REQ;
                    grant_nxt   = win;
                    ba_addr_nxt = addr_arr[win];
                    ba_rd_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (ba_ack) begin
                    ba_rd_nxt = 1'b0;
                    // ack and rdy together complete as if DATA were passed through
                    if (ba_rdy) done = 1'b1;
                    else        state_nxt = DATA;
                end
            end
            DATA: begin
                if (ba_rdy) done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                ba_rd_nxt = 1'b0;
            end
        endcase
        if (done) begin
            state_nxt          = IDLE;
            slot_dout_nxt      = sdram_dout;
            // A slot that gave up its request gets no ok pulse
            slot_ok_nxt[grant] = slot_req[grant];
            rr_nxt             = grant_inc;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr        <= '0;
            ba_rd     <= 1'b0;
            ba_addr   <= '0;
            slot_ok   <= '0;
            slot_dout <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr        <= rr_nxt;
            ba_rd     <= ba_rd_nxt;
            ba_addr   <= ba_addr_nxt;
            slot_ok   <= slot_ok_nxt;
            slot_dout <= slot_dout_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_jtframe_bank_arbiter.sv
// Testbench for jtframe_bank_arbiter: directed scenarios followed by random
// traffic, all checked each cycle against a transaction-level reference model.
module tb_jtframe_bank_arbiter;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;

    logic                clk;
    logic                rst_n;
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [DW-1:0]       slot_dout;
    logic                ba_rd;
    logic [AW-1:0]       ba_addr;
    logic                ba_ack;
    logic                ba_rdy;
    logic [DW-1:0]       sdram_dout;
    logic                busy;

    int    errors = 0;
    int    checks = 0;
    string phase  = "init";

    // Reference model: one outstanding read, described by what has happened to it
    bit             m_busy;
    bit             m_acked;
    bit             m_rd;
    int             m_grant;
    int             m_rr;
    logic [AW-1:0]  m_addr;
    logic [SLOTS-1:0] m_ok;
    logic [DW-1:0]  m_dout;

    jtframe_bank_arbiter #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .ba_rd       (ba_rd),
        .ba_addr     (ba_addr),
        .ba_ack      (ba_ack),
        .ba_rdy      (ba_rdy),
        .sdram_dout  (sdram_dout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] get_addr(input int i);
        logic [SLOTS*AW-1:0] v;
        v = slot_addr;
        return v[i*AW +: AW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic model_reset();
        m_busy = 0; m_acked = 0; m_rd = 0; m_grant = 0; m_rr = 0;
        m_addr = '0; m_ok = '0; m_dout = '0;
    endtask

    // Applies the arbitration rules to the inputs present at a clock edge
    task automatic model_edge();
        logic [SLOTS-1:0] ok_n;
        bit fin;
        int w;
        ok_n = '0;
        fin  = 0;
        if (!m_busy) begin
            if (!downloading && slot_req != '0) begin
                w = -1;
                for (int k = 0; k < SLOTS; k++) begin
                    int s;
                    s = (m_rr + k) % SLOTS;
                    if (w < 0 && slot_req[s]) w = s;
                end
                m_grant = w;
                m_addr  = get_addr(w);
                m_rd    = 1;
                m_busy  = 1;
                m_acked = 0;
            end
        end else if (!m_acked) begin
            if (ba_ack) begin
                m_rd = 0;
                if (ba_rdy) fin = 1;
                else        m_acked = 1;
            end
        end else if (ba_rdy) begin
            fin = 1;
        end
        if (fin) begin
            m_dout = sdram_dout;
            if (slot_req[m_grant]) ok_n[m_grant] = 1'b1;
            m_rr    = (m_grant + 1) % SLOTS;
            m_busy  = 0;
            m_acked = 0;
        end
        m_ok = ok_n;
    endtask

    task automatic compare_all();
        check("ba_rd",     64'(ba_rd),     64'(m_rd));
        check("ba_addr",   64'(ba_addr),   64'(m_addr));
        check("slot_ok",   64'(slot_ok),   64'(m_ok));
        check("slot_dout", 64'(slot_dout), 64'(m_dout));
        check("busy",      64'(busy),      64'(m_busy));
    endtask

    // One clock: model follows the edge, outputs compared just after it
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges, released after one edge
    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_ba_rd", 64'(ba_rd),   64'(0));
        check("rst_ok",    64'(slot_ok), 64'(0));
        check("rst_busy",  64'(busy),    64'(0));
        slot_req = '0; ba_ack = 0; ba_rdy = 0; downloading = 0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Serve the granted read: ack after ack_dly cycles, rdy rdy_dly cycles later
    task automatic transact(input int ack_dly, input int rdy_dly, input logic [DW-1:0] d);
        repeat (ack_dly) cyc();
        ba_ack = 1;
        if (rdy_dly == 0) begin ba_rdy = 1; sdram_dout = d; end
        cyc();
        ba_ack = 0; ba_rdy = 0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) cyc();
            ba_rdy = 1; sdram_dout = d;
            cyc();
            ba_rdy = 0;
        end
        slot_req = slot_req & ~slot_ok;
    endtask

    initial begin
        logic [SLOTS-1:0] released;
        rst_n = 0; downloading = 0; slot_req = '0; slot_addr = '0;
        ba_ack = 0; ba_rdy = 0; sdram_dout = '0;
        model_reset();
        set_addr(0, 22'h000A0); set_addr(1, 22'h001B1);
        set_addr(2, 22'h01234); set_addr(3, 22'h003C3);
        #1;
        phase = "reset";
        compare_all();
        cyc();
        rst_n = 1;

        // Single slot
        phase = "single";
        slot_req = 4'b0100;
        cyc();
        check("grant_rd", 64'(ba_rd), 64'(1));
        check("grant_addr", 64'(ba_addr), 64'(22'h1234));
        transact(2, 3, 16'hBEEF);
        check("ok", 64'(slot_ok), 64'(4'b0100));
        check("dout", 64'(slot_dout), 64'(16'hBEEF));
        cyc();
        check("ok_pulse", 64'(slot_ok), 64'(0));

        // All four requesting, each releasing on its ok and re-raising later
        phase = "rr_order";
        reset_dut();
        slot_req = 4'b1111;
        released = '0;
        for (int k = 0; k < 5; k++) begin
            check("no_b2b", 64'(ba_rd), 64'(0));
            cyc();
            check("order", 64'(ba_addr), 64'(get_addr(k % SLOTS)));
            slot_req = slot_req | released;
            released = slot_ok;
            transact(1, 2, DW'(16'h1000 + k));
            released = 4'(1 << (k % SLOTS));
        end
        slot_req = '0;
        cyc();

        // Download blocks new grants
        phase = "download";
        reset_dut();
        downloading = 1; slot_req = 4'b0011;
        repeat (3) cyc();
        check("dl_rd", 64'(ba_rd), 64'(0));
        check("dl_busy", 64'(busy), 64'(0));
        downloading = 0;
        cyc();
        check("dl_grant", 64'(ba_addr), 64'(get_addr(0)));
        transact(0, 1, 16'h5A5A);
        transact(0, 0, 16'h0000);
        slot_req = '0;
        repeat (2) cyc();

        // Request dropped during DATA
        phase = "drop";
        reset_dut();
        slot_req = 4'b0110;
        cyc();
        ba_ack = 1; cyc(); ba_ack = 0;
        slot_req[1] = 1'b0;
        cyc();
        ba_rdy = 1; sdram_dout = 16'h7777; cyc(); ba_rdy = 0;
        check("drop_ok", 64'(slot_ok), 64'(0));
        cyc();
        cyc();
        check("drop_next", 64'(ba_addr), 64'(get_addr(2)));
        transact(1, 1, 16'h2222);

        // ack and rdy together
        phase = "ack_rdy";
        slot_req = 4'b1000;
        cyc(); cyc();
        transact(0, 0, 16'hCAFE);
        check("same_ok", 64'(slot_ok), 64'(4'b1000));
        check("same_busy", 64'(busy), 64'(0));
        check("same_dout", 64'(slot_dout), 64'(16'hCAFE));

        // Reset mid-DATA after the pointer has moved away from zero
        phase = "rst_data";
        slot_req = 4'b0100;
        cyc(); cyc();
        transact(0, 1, 16'h3333);
        slot_req = 4'b0010;
        cyc(); cyc();
        ba_ack = 1; cyc(); ba_ack = 0;
        check("in_data", 64'(busy), 64'(1));
        reset_dut();
        slot_req = 4'b1001;
        cyc();
        check("rr_zero", 64'(ba_addr), 64'(get_addr(0)));
        transact(1, 1, 16'h4444);
        cyc(); cyc();
        check("slot3", 64'(ba_addr), 64'(get_addr(3)));
        transact(0, 2, 16'h5555);
        slot_req = '0;
        cyc();

        // Random traffic
        phase = "random";
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                reset_dut();
            end
            ba_ack = m_rd && ($urandom % 3 == 0);
            if (m_busy && (m_acked || ba_ack)) ba_rdy = ($urandom % 3 == 0);
            else                               ba_rdy = ($urandom % 8 == 0);
            sdram_dout = DW'($urandom);
            if ($urandom % 20 == 0) downloading = ~downloading;
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_ok[i]) begin
                    slot_req[i] = 1'b0;
                end else if (!slot_req[i]) begin
                    if ($urandom % 4 == 0) begin
                        slot_req[i] = 1'b1;
                        set_addr(i, AW'($urandom));
                    end
                end else if ($urandom % 32 == 0) begin
                    slot_req[i] = 1'b0;
                end
                if ($urandom % 8 == 0) set_addr(i, AW'($urandom));
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
